ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL accept ID/EX control: regDst_in, aluSrc_in, memtoReg_in, regWrite_in, memWrite_in  in  1 each; aluOp_in  in  2.
REQ-003 SHALL accept ID/EX data: rsAddr_in, rtAddr_in, rdAddr_in  in  5; imme_in, rsData_in, rtData_in  in  32 (imme_in sign-extended; imme_in[5:0] = funct).
REQ-004 SHALL accept writeback forward: wbRegWrite_in  in  1; wbAddr_in  in  5; wbData_in  in  32.
REQ-005 SHALL drive EX/MEM outputs (registered): memtoReg_out, regWrite_out, memWrite_out  out  1; wrAddr_out  out  5; aluResult_out, storeData_out  out  32.
REQ-006 SHALL drive stall_out  out  1 (combinational; upstream holds IF/ID and ID/EX while high).

Function
REQ-007 Operand forwarding SHALL select, per source (rs, rt): EX/MEM (regWrite_out, wrAddr_out, aluResult_out) first, then writeback (wbRegWrite_in, wbAddr_in, wbData_in), else register data; address 0 SHALL never be forwarded.
REQ-008 ALU operand B SHALL be imme_in when aluSrc_in=1, else forwarded rt; storeData_out SHALL take forwarded rt.
REQ-009 aluOp decode: 00 add; 01 sub; 11 or with zero-extended imme_in[15:0]; 10 by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 0/1), 0x19 multu, 0x10 mfhi, 0x12 mflo; other funct -> result 0.
REQ-010 add/sub SHALL wrap modulo 2^32, no overflow trap.
REQ-011 wrAddr SHALL be rdAddr_in when regDst_in=1, else rtAddr_in.
REQ-012 Non-multu instructions SHALL complete in 1 cycle: EX/MEM outputs update on the next rising edge.
REQ-013 multu SHALL use an iterative shift-add multiplier; FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: multu present -> capture forwarded rs/rt, counter=0, go BUSY; stall_out=1 this cycle.
REQ-015 BUSY: one partial-product step per cycle; stall_out=1; after 32nd step (counter=31) write 64-bit product to HI (upper) / LO (lower), go DONE.
REQ-016 DONE: stall_out=0; instruction retires as bubble; go IDLE next cycle. Total stall = 33 cycles.
REQ-017 While stall_out=1, EX/MEM register SHALL load a bubble (regWrite_out=0, memWrite_out=0, memtoReg_out=0); other fields hold.
REQ-018 Operand changes on inputs during BUSY SHALL not affect the product.
REQ-019 mfhi/mflo immediately after multu (in DONE+1) SHALL read the new HI/LO.
REQ-020 multu register writes SHALL not occur: multu never asserts regWrite_out.

Reset
REQ-021 rst=1 at a clock edge SHALL clear all EX/MEM outputs to 0, HI/LO to 0, counter to 0, FSM to IDLE; stall_out=0 while in reset.
REQ-022 rst during BUSY SHALL abort the multiply; HI/LO SHALL read 0 afterward.

Structure
REQ-023 aluOp encodings, funct codes, and FSM state encodings SHALL live in a shared package (mips_defs) used by decoder and this block.
REQ-024 The multiplier SHALL be a sub-module named mul_iter (start, busy, done, 64-bit product); forwarding and ALU stay in ex_stage.

Verification
REQ-025 add rd=3 rs=1(5) rt=2(7) -> aluResult_out=12, wrAddr_out=3, regWrite_out=1 one cycle later.
REQ-026 back-to-back add r3 then sub r4=r3-r1 (r3 stale 0 in rsData) -> EX/MEM forward gives r4=7; same case via writeback port only -> 7; both match -> EX/MEM value wins.
REQ-027 multu 0xFFFFFFFF x 0xFFFFFFFF -> stall_out high exactly 33 cycles, then mfhi=0xFFFFFFFE, mflo=0x00000001.
REQ-028 slt -1 vs 1 -> 1; ori imme=0xFFFF8000 (sign-ext) with rs=0 -> 0x00008000; rd address 0 with wbAddr 0 -> no forward.
REQ-029 rst asserted at BUSY cycle 10 -> next cycle IDLE, stall_out=0, all outputs 0, mfhi=0.

Source files
------------

// File: rtl/mips_defs.sv
// mips_defs: ALU op, funct and multiplier state encodings shared by decode and execute
package mips_defs;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_ORI = 2'b11;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_SLT = 6'h2A, F_MULTU = 6'h19, F_MFHI = 6'h10, F_MFLO = 6'h12;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: 32-step shift-add unsigned multiplier holding the HI/LO product
module mul_iter import mips_defs::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  mul_state_t state;
  logic [4:0] cnt;
  logic [63:0] acc, mcand, acc_nx;
  logic [31:0] mplr;
  assign acc_nx = acc + (mplr[0] ? mcand : 64'd0);
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplr <= '0;
      product <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= BUSY;
          cnt <= '0;
          acc <= '0;
          mcand <= {32'd0, a};
          mplr <= b;
        end
        BUSY: begin
          acc <= acc_nx;
          mcand <= mcand << 1;
          mplr <= mplr >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            product <= acc_nx;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with operand forwarding, ALU and iterative multu stall
module ex_stage import mips_defs::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        regDst_in,
  input  logic        aluSrc_in,
  input  logic        memtoReg_in,
  input  logic        regWrite_in,
  input  logic        memWrite_in,
  input  logic [1:0]  aluOp_in,
  input  logic [4:0]  rsAddr_in,
  input  logic [4:0]  rtAddr_in,
  input  logic [4:0]  rdAddr_in,
  input  logic [31:0] imme_in,
  input  logic [31:0] rsData_in,
  input  logic [31:0] rtData_in,
  input  logic        wbRegWrite_in,
  input  logic [4:0]  wbAddr_in,
  input  logic [31:0] wbData_in,
  output logic        memtoReg_out,
  output logic        regWrite_out,
  output logic        memWrite_out,
  output logic [4:0]  wrAddr_out,
  output logic [31:0] aluResult_out,
  output logic [31:0] storeData_out,
  output logic        stall_out
);
  logic [5:0] funct;
  logic [31:0] fwd_a, fwd_b, op_b, sum, diff, r_res, alu, hi, lo;
  logic [63:0] product;
  logic is_multu, mul_busy, mul_done, start;
  assign funct = imme_in[5:0];
  assign is_multu = aluOp_in == ALU_FUNCT && funct == F_MULTU;
  // the newest producer wins; r0 is hardwired zero so it is never forwarded
  assign fwd_a = (regWrite_out && wrAddr_out != 5'd0 && wrAddr_out == rsAddr_in) ? aluResult_out :
                 (wbRegWrite_in && wbAddr_in != 5'd0 && wbAddr_in == rsAddr_in) ? wbData_in : rsData_in;
  assign fwd_b = (regWrite_out && wrAddr_out != 5'd0 && wrAddr_out == rtAddr_in) ? aluResult_out :
                 (wbRegWrite_in && wbAddr_in != 5'd0 && wbAddr_in == rtAddr_in) ? wbData_in : rtData_in;
  assign op_b = aluSrc_in ? imme_in : fwd_b;
  assign sum = fwd_a + op_b;
  assign diff = fwd_a - op_b;
  assign hi = product[63:32];
  assign lo = product[31:0];
  assign r_res = funct == F_ADD  ? sum :
                 funct == F_SUB  ? diff :
                 funct == F_AND  ? fwd_a & op_b :
                 funct == F_OR   ? fwd_a | op_b :
                 funct == F_SLT  ? {31'd0, $signed(fwd_a) < $signed(op_b)} :
                 funct == F_MFHI ? hi :
                 funct == F_MFLO ? lo : 32'd0;
  assign alu = aluOp_in == ALU_ADD ? sum :
               aluOp_in == ALU_SUB ? diff :
               aluOp_in == ALU_ORI ? fwd_a | {16'd0, imme_in[15:0]} : r_res;
  // a multu on the inputs during DONE must not retrigger; it retires instead
  assign start = is_multu && !mul_busy && !mul_done;
  assign stall_out = !rst && (start || mul_busy);
  mul_iter u_mul (
    .clk(clk), .rst(rst), .start(start), .a(fwd_a), .b(fwd_b),
    .busy(mul_busy), .done(mul_done), .product(product)
  );
  always_ff @(posedge clk)
    if (rst) begin
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      memWrite_out <= 1'b0;
      wrAddr_out <= '0;
      aluResult_out <= '0;
      storeData_out <= '0;
    end else if (stall_out) begin
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      memWrite_out <= 1'b0;
    end else begin
      memtoReg_out <= memtoReg_in && !is_multu;
      regWrite_out <= regWrite_in && !is_multu;
      memWrite_out <= memWrite_in && !is_multu;
      wrAddr_out <= regDst_in ? rdAddr_in : rtAddr_in;
      aluResult_out <= alu;
      storeData_out <= fwd_b;
    end
endmodule
